// File: rtl/branch_predict_unit_pkg.sv
// Shared encodings for the branch predict unit: RV32I branch funct3 values,
// 2-bit saturating counter states and the counter update rule.
package branch_predict_unit_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    localparam logic [1:0] CTR_RESET = CTR_WNT;

    // Saturating step of a 2-bit history counter toward the resolved outcome.
    function automatic logic [1:0] ctr_next(input logic [1:0] cur, input logic taken);
        logic [1:0] nxt;
        nxt = cur;
        case (cur)
            CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  nxt = taken ? CTR_ST  : CTR_WT;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predict_unit_resolve.sv
// Execute-stage branch resolution: funct3 decode into taken, mispredict and
// the corrected next PC. Purely combinational.
module branch_resolve
    import branch_predict_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_active,
    input  logic [2:0]      i_funct3,
    input  logic            i_zero,
    input  logic            i_lt,
    input  logic            i_ltu,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_target,
    input  logic            i_pred_taken,
    input  logic [XLEN-1:0] i_pred_target,
    output logic            o_taken_c,
    output logic            o_mispredict_c,
    output logic [XLEN-1:0] o_redirect_pc_c,
    output logic            o_update_c
);

    logic w_known;
    logic w_cond;

    always_comb begin
        w_known         = 1'b1;
        w_cond          = 1'b0;
        o_taken_c       = 1'b0;
        o_mispredict_c  = 1'b0;
        o_redirect_pc_c = '0;
        o_update_c      = 1'b0;

        case (i_funct3)
            F3_BEQ:  w_cond = i_zero;
            F3_BNE:  w_cond = ~i_zero;
            F3_BLT:  w_cond = i_lt;
            F3_BGE:  w_cond = ~i_lt;
            F3_BLTU: w_cond = i_ltu;
            F3_BGEU: w_cond = ~i_ltu;
            default: w_known = 1'b0;
        endcase

        if (i_active) begin
            o_taken_c       = w_known & w_cond;
            // Direction wrong, or both taken but the carried target is stale.
            o_mispredict_c  = (o_taken_c != i_pred_taken) |
                              (o_taken_c & i_pred_taken & (i_pred_target != i_target));
            o_redirect_pc_c = o_taken_c ? i_target : i_pc + XLEN'(4);
            o_update_c      = w_known;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predict unit: direct-mapped, tagless 2-bit counter table with target
// buffer for fetch lookup, execute-stage resolution and saturating statistics.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned IDX_BITS = 6,
    parameter int unsigned CNT_W    = 32,
    parameter bit          PRED_EN  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  f_pc,
    output logic             f_pred_taken,
    output logic [XLEN-1:0]  f_pred_target,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [2:0]       ex_funct3,
    input  logic             ex_zero,
    input  logic             ex_lt,
    input  logic             ex_ltu,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_pred_target,
    output logic             ex_taken,
    output logic             ex_mispredict,
    output logic [XLEN-1:0]  ex_redirect_pc,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispredicts
);

    localparam int unsigned ENTRIES = 1 << IDX_BITS;

    logic [1:0]          r_ctr    [ENTRIES];
    logic [XLEN-1:0]     r_target [ENTRIES];
    logic [ENTRIES-1:0]  r_valid;
    logic [CNT_W-1:0]    r_stat_br;
    logic [CNT_W-1:0]    r_stat_mp;

    logic [IDX_BITS-1:0] w_f_idx;
    logic [IDX_BITS-1:0] w_ex_idx;
    logic                w_update;
    logic                w_unused_pc_bits;

    assign w_f_idx          = f_pc[IDX_BITS+1:2];
    assign w_ex_idx         = ex_pc[IDX_BITS+1:2];
    assign w_unused_pc_bits = ^{f_pc[XLEN-1:IDX_BITS+2], f_pc[1:0]};

    // Lookup reads stored state only, so a same-cycle update is not visible.
    assign f_pred_taken  = PRED_EN & r_valid[w_f_idx] & r_ctr[w_f_idx][1];
    assign f_pred_target = f_pred_taken ? r_target[w_f_idx] : '0;

    branch_resolve #(.XLEN(XLEN)) u_resolve (
        .i_active        (ex_valid & ex_is_branch),
        .i_funct3        (ex_funct3),
        .i_zero          (ex_zero),
        .i_lt            (ex_lt),
        .i_ltu           (ex_ltu),
        .i_pc            (ex_pc),
        .i_target        (ex_target),
        .i_pred_taken    (ex_pred_taken),
        .i_pred_target   (ex_pred_target),
        .o_taken_c       (ex_taken),
        .o_mispredict_c  (ex_mispredict),
        .o_redirect_pc_c (ex_redirect_pc),
        .o_update_c      (w_update)
    );

    // History table: counters train both ways, target/valid only on taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                r_ctr[i]    <= CTR_RESET;
                r_target[i] <= '0;
            end
            r_valid <= '0;
        end else if (w_update) begin
            r_ctr[w_ex_idx] <= ctr_next(r_ctr[w_ex_idx], ex_taken);
            if (ex_taken) begin
                r_target[w_ex_idx] <= ex_target;
                r_valid[w_ex_idx]  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_br <= '0;
            r_stat_mp <= '0;
        end else if (w_update) begin
            if (r_stat_br != '1)
                r_stat_br <= r_stat_br + CNT_W'(1);
            if (ex_mispredict && (r_stat_mp != '1))
                r_stat_mp <= r_stat_mp + CNT_W'(1);
        end
    end

    assign stat_branches    = r_stat_br;
    assign stat_mispredicts = r_stat_mp;

endmodule
